mc_controller: RTL and testbench
================================

// Module: mc_controller
// PURPOSE
//  Multi-cycle control FSM for the MIPS core. It replaces single-cycle decode with a sequenced IF/ID/EXE/MEM/WB flow.
//  It shares one memory port between instruction fetch and data access, using a req/ready handshake.
//  It drives the existing datapath strobes, with encodings per macro.v: RegDst, ALUSrc, Mem2Reg, NPCSel, EXTOp, ALUOp, FlagOp.
//  It adds IRWr, mem_req and a retired-instruction counter.
// PARAMETERS
//  CNT_W   32   width of retired-instruction counter (wraps modulo 2^CNT_W)
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  opcode     in   6      IR[31:26], stable from ID until return to IF
//  funct      in   6      IR[5:0]
//  NFlag      in   32     ALU flags; bits `FLAG_BIT_ZERO / `FLAG_BIT_OVERFLOW used
//  mem_ready  in   1      memory completes current mem_req this cycle
//  mem_req    out  1      memory access request (fetch in IF, data in MEM)
//  MemWr      out  1      write qualifier for mem_req (sw only)
//  IRWr       out  1      load instruction register
//  PCWr       out  1      PC write enable
//  NPCSel     out  2      next-PC source
//  RegWr      out  1      register-file write enable
//  RegDst     out  2      write-register select
//  Mem2Reg    out  2      write-back data select
//  ALUSrc     out  1      ALU B operand select
//  EXTOp      out  2      immediate extend mode
//  ALUOp      out  3      ALU operation
//  FlagOp     out  2      flag register op
//  illegal    out  1      1-cycle pulse: unknown opcode/funct in ID
//  state      out  3      current state (IF=0 ID=1 EXE=2 MEM=3 WB=4)
//  retired    out  CNT_W  count of completed instructions
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IF, retired=0. All strobes (mem_req, MemWr, IRWr, PCWr, RegWr, illegal) are 0.
//   Selects are _ZZ/_DIS.
//   Reset asserted mid-access drops mem_req immediately. An abandoned access leaves no RegWr/PCWr.
//  Outputs: combinational from state + opcode/funct/NFlag/mem_ready.
//   Strobes are high only in the states listed below; 0 elsewhere.
//  IF:
//   - mem_req=1, MemWr=0. Stay in IF while mem_ready=0.
//   - On mem_ready: IRWr=1, PCWr=1, NPCSel=PC_ADD_4; go to ID.
//  ID:
//   - j: PCWr=1, NPCSel=J_JMP -> IF.
//   - jal: additionally RegWr=1, RegDst=RET, Mem2Reg=RET -> IF.
//   - jr: PCWr=1, NPCSel=REG_JMP -> IF.
//   - nop (SPECIAL, funct 0): -> IF.
//   - Unknown encoding: illegal=1, no writes -> IF.
//   - All others -> EXE.
//  EXE: ALUSrc/EXTOp/ALUOp per instruction (same values as single-cycle table).
//   - beq: ALUOp=SUB. If zero: PCWr=1, NPCSel=BEQ_JMP. -> IF.
//   - lw/sw -> MEM.
//   - addu/subu/slt/ori/lui/addi/addiu -> WB.
//  MEM: EXE operand selects held.
//   - mem_req=1, MemWr=(sw). Stay while mem_ready=0.
//   - On ready: sw -> IF; lw -> WB.
//  WB: RegWr=1; RegDst=RD (R-type) else RT; Mem2Reg=RAM (lw) else ALU; EXE selects held.
//   - addi with overflow: FlagOp=SET_AND_WR, else DIS.
//   - -> IF.
//  retired: +1 on the cycle the FSM transitions back to IF. Covers every instruction, including nop and illegal.
//  Branch/jump targets are computed by the datapath from the already-incremented PC.
//  Latency with mem_ready=1: j/jal/jr/nop=2, beq=3, R/I ALU=4, sw=4, lw=5 cycles; each memory wait cycle adds 1.
//  mem_ready outside IF/MEM is ignored. mem_ready is sampled only while mem_req=1.
// TESTING
//  1. rst_n=0 mid-MEM of lw (mem_ready=0) -> state=0, mem_req=0, RegWr=0 same cycle; retired=0.
//  2. addu (op 0x00, funct 0x21), mem_ready=1 -> states 0,1,2,4,0; RegWr=1 only in WB, RegDst=RD.
//     retired +1 after 4 cycles.
//  3. lw (op 0x23), mem_ready low 3 cycles in MEM -> 8 cycles total. mem_req held high throughout MEM; MemWr=0.
//     WB: Mem2Reg=RAM.
//  4. sw (op 0x2B) -> MEM asserts mem_req=1, MemWr=1; no RegWr cycle; back to IF after 4 cycles.
//  5. beq (op 0x04): zero=1 -> PCWr=1, NPCSel=BEQ_JMP in EXE; zero=0 -> PCWr=0 in EXE. Both return in 3 cycles.
//  6. jal (0x03) -> ID: PCWr=RegWr=1, RegDst=RET.
//     opcode 0x3F -> illegal pulse 1 cycle, no writes, retired still +1.

Source files
------------

// File: rtl/mc_controller_if.sv
// Control bundle between the multi-cycle controller and the datapath/memory port.
// Latency: none (wires only).
// Backpressure: the memory side stalls the controller by holding mem_ready low while mem_req is high.
interface mc_controller_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic [31:0]      NFlag;
    logic             mem_ready;
    logic             mem_req;
    logic             MemWr;
    logic             IRWr;
    logic             PCWr;
    logic [1:0]       NPCSel;
    logic             RegWr;
    logic [1:0]       RegDst;
    logic [1:0]       Mem2Reg;
    logic             ALUSrc;
    logic [1:0]       EXTOp;
    logic [2:0]       ALUOp;
    logic [1:0]       FlagOp;
    logic             illegal;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;

    // Controller side
    modport master (
        input  opcode, funct, NFlag, mem_ready,
        output mem_req, MemWr, IRWr, PCWr, NPCSel, RegWr, RegDst, Mem2Reg,
               ALUSrc, EXTOp, ALUOp, FlagOp, illegal, state, retired
    );

    // Datapath / memory side
    modport slave (
        output opcode, funct, NFlag, mem_ready,
        input  mem_req, MemWr, IRWr, PCWr, NPCSel, RegWr, RegDst, Mem2Reg,
               ALUSrc, EXTOp, ALUOp, FlagOp, illegal, state, retired
    );
endinterface

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM (IF/ID/EXE/MEM/WB) sharing one memory port for fetch and data.
// Latency: 2..5 cycles per instruction with mem_ready=1; every memory wait cycle adds one.
// Backpressure: IF and MEM hold mem_req and stay put until mem_ready; strobes are combinational.
module mc_controller #(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    mc_controller_if.master   bus
);
    // Datapath select encodings; 0 is the idle/don't-care value for every select.
    localparam logic [1:0] NPC_PC4 = 2'd0, NPC_J = 2'd1, NPC_REG = 2'd2, NPC_BEQ = 2'd3;
    localparam logic [1:0] RD_ZZ = 2'd0, RD_RT = 2'd1, RD_RD = 2'd2, RD_RET = 2'd3;
    localparam logic [1:0] M2R_ZZ = 2'd0, M2R_ALU = 2'd1, M2R_RAM = 2'd2, M2R_RET = 2'd3;
    localparam logic       SRC_REG = 1'b0, SRC_IMM = 1'b1;
    localparam logic [1:0] EXT_ZZ = 2'd0, EXT_ZERO = 2'd1, EXT_SIGN = 2'd2, EXT_LUI = 2'd3;
    localparam logic [2:0] ALU_ZZ = 3'd0, ALU_ADD = 3'd1, ALU_SUB = 3'd2, ALU_OR = 3'd3, ALU_SLT = 3'd4;
    localparam logic [1:0] FLAG_DIS = 2'd0, FLAG_SET_AND_WR = 2'd1;
    localparam int         FLAG_BIT_ZERO = 0, FLAG_BIT_OVERFLOW = 1;

    localparam logic [5:0] OP_SPECIAL = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                           OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_ORI = 6'h0D, OP_LUI = 6'h0F,
                           OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] F_NOP = 6'h00, F_JR = 6'h08, F_ADDU = 6'h21, F_SUBU = 6'h23, F_SLT = 6'h2A;

    typedef enum logic [2:0] {S_IF = 3'd0, S_ID = 3'd1, S_EXE = 3'd2, S_MEM = 3'd3, S_WB = 3'd4} state_t;
    typedef enum logic [3:0] {C_ILL, C_NOP, C_J, C_JAL, C_JR, C_BEQ, C_ALU, C_LW, C_SW} cls_t;

    state_t           state_q, state_nxt;
    logic [CNT_W-1:0] retired_q;

    cls_t       cls;
    logic       is_r, is_addi;
    logic       dec_alusrc;
    logic [1:0] dec_extop;
    logic [2:0] dec_aluop;

    logic       mem_req, memwr, irwr, pcwr, regwr, illegal, alusrc;
    logic [1:0] npcsel, regdst, mem2reg, extop, flagop;
    logic [2:0] aluop;

    // Only the zero and overflow flags matter to control.
    logic unused_flag_bits;
    assign unused_flag_bits = ^{bus.NFlag[31:2]};

    // Instruction class and EXE operand selects (same values as the single-cycle decode table).
    always_comb begin
        cls        = C_ILL;
        is_r       = 1'b0;
        is_addi    = 1'b0;
        dec_alusrc = SRC_REG;
        dec_extop  = EXT_ZZ;
        dec_aluop  = ALU_ZZ;
        case (bus.opcode)
            OP_SPECIAL: begin
                is_r = 1'b1;
                case (bus.funct)
                    F_NOP:  cls = C_NOP;
                    F_JR:   cls = C_JR;
                    F_ADDU: begin cls = C_ALU; dec_aluop = ALU_ADD; end
                    F_SUBU: begin cls = C_ALU; dec_aluop = ALU_SUB; end
                    F_SLT:  begin cls = C_ALU; dec_aluop = ALU_SLT; end
                    default: cls = C_ILL;
                endcase
            end
            OP_J:     cls = C_J;
            OP_JAL:   cls = C_JAL;
            OP_BEQ:   begin cls = C_BEQ; dec_aluop = ALU_SUB; end
            OP_ORI:   begin cls = C_ALU; dec_alusrc = SRC_IMM; dec_extop = EXT_ZERO; dec_aluop = ALU_OR;  end
            OP_LUI:   begin cls = C_ALU; dec_alusrc = SRC_IMM; dec_extop = EXT_LUI;  dec_aluop = ALU_ADD; end
            OP_ADDI:  begin cls = C_ALU; dec_alusrc = SRC_IMM; dec_extop = EXT_SIGN; dec_aluop = ALU_ADD; is_addi = 1'b1; end
            OP_ADDIU: begin cls = C_ALU; dec_alusrc = SRC_IMM; dec_extop = EXT_SIGN; dec_aluop = ALU_ADD; end
            OP_LW:    begin cls = C_LW;  dec_alusrc = SRC_IMM; dec_extop = EXT_SIGN; dec_aluop = ALU_ADD; end
            OP_SW:    begin cls = C_SW;  dec_alusrc = SRC_IMM; dec_extop = EXT_SIGN; dec_aluop = ALU_ADD; end
            default:  cls = C_ILL;
        endcase
    end

    // Next state and strobes; everything is forced idle while reset is held so an
    // in-flight access is dropped in the same cycle reset asserts.
    always_comb begin
        state_nxt = state_q;
        mem_req   = 1'b0;
        memwr     = 1'b0;
        irwr      = 1'b0;
        pcwr      = 1'b0;
        regwr     = 1'b0;
        illegal   = 1'b0;
        npcsel    = NPC_PC4;
        regdst    = RD_ZZ;
        mem2reg   = M2R_ZZ;
        alusrc    = SRC_REG;
        extop     = EXT_ZZ;
        aluop     = ALU_ZZ;
        flagop    = FLAG_DIS;
        if (rst_n) begin
            case (state_q)
                S_IF: begin
                    mem_req = 1'b1;
                    if (bus.mem_ready) begin
                        irwr      = 1'b1;
                        pcwr      = 1'b1;
                        npcsel    = NPC_PC4;
                        state_nxt = S_ID;
                    end
                end
                S_ID: begin
                    state_nxt = S_IF;
                    case (cls)
                        C_J:   begin pcwr = 1'b1; npcsel = NPC_J; end
                        C_JAL: begin pcwr = 1'b1; npcsel = NPC_J; regwr = 1'b1; regdst = RD_RET; mem2reg = M2R_RET; end
                        C_JR:  begin pcwr = 1'b1; npcsel = NPC_REG; end
                        C_NOP: ;
                        C_ILL: illegal = 1'b1;
                        default: state_nxt = S_EXE;
                    endcase
                end
                S_EXE: begin
                    alusrc = dec_alusrc;
                    extop  = dec_extop;
                    aluop  = dec_aluop;
                    if (cls == C_BEQ) begin
                        if (bus.NFlag[FLAG_BIT_ZERO]) begin
                            pcwr   = 1'b1;
                            npcsel = NPC_BEQ;
                        end
                        state_nxt = S_IF;
                    end else if (cls == C_LW || cls == C_SW) begin
                        state_nxt = S_MEM;
                    end else begin
                        state_nxt = S_WB;
                    end
                end
                S_MEM: begin
                    alusrc  = dec_alusrc;
                    extop   = dec_extop;
                    aluop   = dec_aluop;
                    mem_req = 1'b1;
                    memwr   = (cls == C_SW);
                    if (bus.mem_ready) state_nxt = (cls == C_SW) ? S_IF : S_WB;
                end
                S_WB: begin
                    alusrc    = dec_alusrc;
                    extop     = dec_extop;
                    aluop     = dec_aluop;
                    regwr     = 1'b1;
                    regdst    = is_r ? RD_RD : RD_RT;
                    mem2reg   = (cls == C_LW) ? M2R_RAM : M2R_ALU;
                    flagop    = (is_addi && bus.NFlag[FLAG_BIT_OVERFLOW]) ? FLAG_SET_AND_WR : FLAG_DIS;
                    state_nxt = S_IF;
                end
                default: state_nxt = S_IF;
            endcase
        end
    end

    // State register and retired count; an instruction retires on its return to IF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IF;
            retired_q <= '0;
        end else begin
            state_q <= state_nxt;
            if (state_q != S_IF && state_nxt == S_IF) retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign bus.mem_req = mem_req;
    assign bus.MemWr   = memwr;
    assign bus.IRWr    = irwr;
    assign bus.PCWr    = pcwr;
    assign bus.NPCSel  = npcsel;
    assign bus.RegWr   = regwr;
    assign bus.RegDst  = regdst;
    assign bus.Mem2Reg = mem2reg;
    assign bus.ALUSrc  = alusrc;
    assign bus.EXTOp   = extop;
    assign bus.ALUOp   = aluop;
    assign bus.FlagOp  = flagop;
    assign bus.illegal = illegal;
    assign bus.state   = state_q;
    assign bus.retired = retired_q;
endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: directed scenarios plus randomized instructions against a phase-level model.
// Latency: inputs applied 1 time unit after the rising edge, outputs sampled 1 unit later.
// Backpressure: memory waits are injected randomly in IF and MEM.
module tb_mc_controller;
    localparam logic [1:0] NPC_PC4 = 2'd0, NPC_J = 2'd1, NPC_REG = 2'd2, NPC_BEQ = 2'd3;
    localparam logic [1:0] RD_RT = 2'd1, RD_RD = 2'd2, RD_RET = 2'd3;
    localparam logic [1:0] M2R_ALU = 2'd1, M2R_RAM = 2'd2, M2R_RET = 2'd3;
    localparam logic [1:0] EXT_ZZ = 2'd0, EXT_ZERO = 2'd1, EXT_SIGN = 2'd2, EXT_LUI = 2'd3;
    localparam logic [2:0] ALU_ADD = 3'd1, ALU_SUB = 3'd2, ALU_OR = 3'd3, ALU_SLT = 3'd4;
    localparam logic [1:0] FLAG_DIS = 2'd0, FLAG_SET = 2'd1;
    localparam int IF = 0, ID = 1, EXE = 2, MEM = 3, WB = 4;
    localparam int K_ILL = 0, K_NOP = 1, K_J = 2, K_JAL = 3, K_JR = 4, K_BEQ = 5, K_ALU = 6, K_LW = 7, K_SW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mc_controller_if #(.CNT_W(32)) bus ();
    mc_controller #(.CNT_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int          n_chk = 0;
    int          n_bad = 0;
    logic [31:0] exp_ret = '0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic rdy, input logic [31:0] fl);
        bus.opcode    = op;
        bus.funct     = fn;
        bus.mem_ready = rdy;
        bus.NFlag     = fl;
    endtask

    // Spec table: instruction class, R-type, addi, and the EXE selects {ALUSrc, EXTOp, ALUOp}.
    function automatic void classify(input logic [5:0] op, input logic [5:0] fn, output int kind,
                                     output logic is_r, output logic is_addi, output logic [5:0] sel);
        kind = K_ILL; is_r = 1'b0; is_addi = 1'b0; sel = 6'd0;
        case (op)
            6'h00: begin
                is_r = 1'b1;
                case (fn)
                    6'h00: kind = K_NOP;
                    6'h08: kind = K_JR;
                    6'h21: begin kind = K_ALU; sel = {1'b0, EXT_ZZ, ALU_ADD}; end
                    6'h23: begin kind = K_ALU; sel = {1'b0, EXT_ZZ, ALU_SUB}; end
                    6'h2A: begin kind = K_ALU; sel = {1'b0, EXT_ZZ, ALU_SLT}; end
                    default: kind = K_ILL;
                endcase
            end
            6'h02: kind = K_J;
            6'h03: kind = K_JAL;
            6'h04: begin kind = K_BEQ; sel = {1'b0, EXT_ZZ, ALU_SUB}; end
            6'h0D: begin kind = K_ALU; sel = {1'b1, EXT_ZERO, ALU_OR}; end
            6'h0F: begin kind = K_ALU; sel = {1'b1, EXT_LUI, ALU_ADD}; end
            6'h08: begin kind = K_ALU; sel = {1'b1, EXT_SIGN, ALU_ADD}; is_addi = 1'b1; end
            6'h09: begin kind = K_ALU; sel = {1'b1, EXT_SIGN, ALU_ADD}; end
            6'h23: begin kind = K_LW;  sel = {1'b1, EXT_SIGN, ALU_ADD}; end
            6'h2B: begin kind = K_SW;  sel = {1'b1, EXT_SIGN, ALU_ADD}; end
            default: kind = K_ILL;
        endcase
    endfunction

    task automatic test_reset;
        rst_n = 1'b0;
        drive(6'h23, 6'h00, 1'b1, 32'hFFFF_FFFF);
        #3;
        n_chk++;
        if ({bus.state, bus.mem_req, bus.MemWr, bus.IRWr, bus.PCWr, bus.RegWr, bus.illegal} !== 9'd0) begin
            n_bad++;
            $display("FAIL reset_strobes got=%h want=0", {bus.state, bus.mem_req, bus.MemWr, bus.IRWr, bus.PCWr, bus.RegWr, bus.illegal});
        end
        n_chk++;
        if ({bus.NPCSel, bus.RegDst, bus.Mem2Reg, bus.ALUSrc, bus.EXTOp, bus.ALUOp, bus.FlagOp} !== 14'd0) begin
            n_bad++;
            $display("FAIL reset_selects got=%h want=0", {bus.NPCSel, bus.RegDst, bus.Mem2Reg, bus.ALUSrc, bus.EXTOp, bus.ALUOp, bus.FlagOp});
        end
        tick;
        tick;
        n_chk++;
        if ({bus.state, bus.retired} !== {3'd0, 32'd0}) begin
            n_bad++;
            $display("FAIL reset_hold got state=%0d retired=%0d want 0 0", bus.state, bus.retired);
        end
        rst_n = 1'b1;
        exp_ret = '0;
    endtask

    task automatic test_addu;
        logic [2:0] st_seq [4] = '{3'd0, 3'd1, 3'd2, 3'd4};
        for (int c = 0; c < 4; c++) begin
            drive(6'h00, 6'h21, 1'b1, 32'h0);
            #1;
            n_chk++;
            if ({bus.state, bus.RegWr} !== {st_seq[c], (c == 3)}) begin
                n_bad++;
                $display("FAIL addu_cycle%0d got state=%0d RegWr=%b want state=%0d RegWr=%b", c, bus.state, bus.RegWr, st_seq[c], (c == 3));
            end
            if (c == 3) begin
                n_chk++;
                if (bus.RegDst !== RD_RD) begin
                    n_bad++;
                    $display("FAIL addu_regdst got=%0d want=%0d", bus.RegDst, RD_RD);
                end
            end
            tick;
        end
        exp_ret++;
        n_chk++;
        if ({bus.state, bus.retired} !== {3'd0, exp_ret}) begin
            n_bad++;
            $display("FAIL addu_retire got state=%0d retired=%0d want 0 %0d", bus.state, bus.retired, exp_ret);
        end
    endtask

    task automatic test_lw_wait;
        logic [2:0] st_seq [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3};
        for (int c = 0; c < 7; c++) begin
            drive(6'h23, 6'h00, (c < 3 || c == 6), 32'h0);
            #1;
            n_chk++;
            if ({bus.state, bus.RegWr} !== {st_seq[c], 1'b0}) begin
                n_bad++;
                $display("FAIL lw_cycle%0d got state=%0d RegWr=%b want state=%0d RegWr=0", c, bus.state, bus.RegWr, st_seq[c]);
            end
            if (c >= 3) begin
                n_chk++;
                if ({bus.mem_req, bus.MemWr} !== 2'b10) begin
                    n_bad++;
                    $display("FAIL lw_mem%0d got mem_req=%b MemWr=%b want 1 0", c, bus.mem_req, bus.MemWr);
                end
            end
            tick;
        end
        #1;
        n_chk++;
        if ({bus.state, bus.RegWr, bus.Mem2Reg, bus.RegDst} !== {3'd4, 1'b1, M2R_RAM, RD_RT}) begin
            n_bad++;
            $display("FAIL lw_wb got state=%0d RegWr=%b Mem2Reg=%0d RegDst=%0d", bus.state, bus.RegWr, bus.Mem2Reg, bus.RegDst);
        end
        tick;
        exp_ret++;
        n_chk++;
        if ({bus.state, bus.retired} !== {3'd0, exp_ret}) begin
            n_bad++;
            $display("FAIL lw_retire got state=%0d retired=%0d want 0 %0d", bus.state, bus.retired, exp_ret);
        end
    endtask

    task automatic test_sw;
        for (int c = 0; c < 4; c++) begin
            drive(6'h2B, 6'h00, 1'b1, 32'h0);
            #1;
            n_chk++;
            if ({bus.state, bus.mem_req, bus.MemWr, bus.RegWr} !== {3'(c), (c == 0 || c == 3), (c == 3), 1'b0}) begin
                n_bad++;
                $display("FAIL sw_cycle%0d got state=%0d mem_req=%b MemWr=%b RegWr=%b", c, bus.state, bus.mem_req, bus.MemWr, bus.RegWr);
            end
            tick;
        end
        exp_ret++;
        n_chk++;
        if ({bus.state, bus.retired} !== {3'd0, exp_ret}) begin
            n_bad++;
            $display("FAIL sw_retire got state=%0d retired=%0d want 0 %0d", bus.state, bus.retired, exp_ret);
        end
    endtask

    task automatic test_beq;
        for (int z = 0; z < 2; z++) begin
            for (int c = 0; c < 3; c++) begin
                drive(6'h04, 6'h00, 1'b1, {31'h2AAA_5555, 1'(z)});
                #1;
                if (c == 2) begin
                    n_chk++;
                    if ({bus.state, bus.PCWr, bus.ALUOp} !== {3'd2, 1'(z), ALU_SUB}) begin
                        n_bad++;
                        $display("FAIL beq_exe_z%0d got state=%0d PCWr=%b ALUOp=%0d", z, bus.state, bus.PCWr, bus.ALUOp);
                    end
                    if (z == 1) begin
                        n_chk++;
                        if (bus.NPCSel !== NPC_BEQ) begin
                            n_bad++;
                            $display("FAIL beq_npc got=%0d want=%0d", bus.NPCSel, NPC_BEQ);
                        end
                    end
                end
                tick;
            end
            exp_ret++;
            n_chk++;
            if ({bus.state, bus.retired} !== {3'd0, exp_ret}) begin
                n_bad++;
                $display("FAIL beq_retire_z%0d got state=%0d retired=%0d want 0 %0d", z, bus.state, bus.retired, exp_ret);
            end
        end
    endtask

    task automatic test_jal_illegal;
        drive(6'h03, 6'h00, 1'b1, 32'h0);
        tick;
        #1;
        n_chk++;
        if ({bus.state, bus.PCWr, bus.RegWr, bus.RegDst, bus.Mem2Reg, bus.NPCSel} !== {3'd1, 1'b1, 1'b1, RD_RET, M2R_RET, NPC_J}) begin
            n_bad++;
            $display("FAIL jal_id got state=%0d PCWr=%b RegWr=%b RegDst=%0d Mem2Reg=%0d NPCSel=%0d",
                     bus.state, bus.PCWr, bus.RegWr, bus.RegDst, bus.Mem2Reg, bus.NPCSel);
        end
        tick;
        exp_ret++;
        drive(6'h3F, 6'h15, 1'b1, 32'h0);
        tick;
        #1;
        n_chk++;
        if ({bus.state, bus.illegal, bus.PCWr, bus.RegWr, bus.IRWr, bus.mem_req, bus.MemWr} !== {3'd1, 6'b100000}) begin
            n_bad++;
            $display("FAIL illegal_id got state=%0d illegal=%b PCWr=%b RegWr=%b IRWr=%b mem_req=%b",
                     bus.state, bus.illegal, bus.PCWr, bus.RegWr, bus.IRWr, bus.mem_req);
        end
        tick;
        exp_ret++;
        n_chk++;
        if ({bus.state, bus.illegal, bus.retired} !== {3'd0, 1'b0, exp_ret}) begin
            n_bad++;
            $display("FAIL illegal_after got state=%0d illegal=%b retired=%0d want 0 0 %0d", bus.state, bus.illegal, bus.retired, exp_ret);
        end
    endtask

    task automatic test_reset_mid_mem;
        for (int c = 0; c < 4; c++) begin
            drive(6'h23, 6'h00, (c < 3), 32'h0);
            if (c < 3) tick;
        end
        #1;
        n_chk++;
        if ({bus.state, bus.mem_req} !== {3'd3, 1'b1}) begin
            n_bad++;
            $display("FAIL rstmem_pre got state=%0d mem_req=%b want 3 1", bus.state, bus.mem_req);
        end
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({bus.state, bus.mem_req, bus.RegWr, bus.PCWr, bus.retired} !== {3'd0, 3'b000, 32'd0}) begin
            n_bad++;
            $display("FAIL rstmem_now got state=%0d mem_req=%b RegWr=%b PCWr=%b retired=%0d",
                     bus.state, bus.mem_req, bus.RegWr, bus.PCWr, bus.retired);
        end
        bus.mem_ready = 1'b1;
        tick;
        n_chk++;
        if ({bus.state, bus.RegWr, bus.PCWr, bus.IRWr, bus.retired} !== {3'd0, 3'b000, 32'd0}) begin
            n_bad++;
            $display("FAIL rstmem_hold got state=%0d RegWr=%b PCWr=%b IRWr=%b retired=%0d",
                     bus.state, bus.RegWr, bus.PCWr, bus.IRWr, bus.retired);
        end
        rst_n = 1'b1;
        exp_ret = '0;
    endtask

    task automatic test_random(input int n);
        logic [5:0] ill_ops [6] = '{6'h01, 6'h05, 6'h10, 6'h20, 6'h3F, 6'h2A};
        logic [5:0] ill_fns [5] = '{6'h01, 6'h20, 6'h22, 6'h09, 6'h3F};
        logic [5:0] ops [14] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h0D, 6'h0F, 6'h08, 6'h09, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03};
        logic [5:0] fns [14] = '{6'h21, 6'h23, 6'h2A, 6'h08, 6'h00, 6'h11, 6'h22, 6'h33, 6'h05, 6'h07, 6'h3C, 6'h19, 6'h2E, 6'h01};
        for (int k = 0; k < n; k++) begin
            int pick, kind, wif, wm, st;
            int sq [$];
            bit rq [$];
            logic [5:0] op, fn, sel;
            logic is_r, is_addi, z, ov, r;
            logic ex_mreq, ex_mwr, ex_ir, ex_pc, ex_rw, ex_ill;
            logic [1:0] ex_npc, ex_rd, ex_m2r, ex_flag;
            pick = $urandom_range(0, 15);
            if (pick < 14) begin
                op = ops[pick];
                fn = fns[pick];
            end else if (pick == 14) begin
                op = ill_ops[$urandom_range(0, 5)];
                fn = 6'($urandom);
            end else begin
                op = 6'h00;
                fn = ill_fns[$urandom_range(0, 4)];
            end
            classify(op, fn, kind, is_r, is_addi, sel);
            wif = $urandom_range(0, 2);
            wm  = $urandom_range(0, 3);
            z   = 1'($urandom);
            ov  = 1'($urandom);
            for (int i = 0; i <= wif; i++) begin sq.push_back(IF); rq.push_back(i == wif); end
            sq.push_back(ID); rq.push_back(1'b0);
            if (kind == K_BEQ || kind == K_ALU || kind == K_LW || kind == K_SW) begin sq.push_back(EXE); rq.push_back(1'b0); end
            if (kind == K_LW || kind == K_SW)
                for (int i = 0; i <= wm; i++) begin sq.push_back(MEM); rq.push_back(i == wm); end
            if (kind == K_ALU || kind == K_LW) begin sq.push_back(WB); rq.push_back(1'b0); end
            for (int i = 0; i < sq.size(); i++) begin
                st = sq[i];
                r  = rq[i];
                if (st == IF) drive(6'($urandom), 6'($urandom), r, $urandom);
                else drive(op, fn, (st == MEM) ? r : 1'($urandom), {30'($urandom), ov, z});
                #1;
                ex_mreq = (st == IF || st == MEM);
                ex_mwr  = (st == MEM && kind == K_SW);
                ex_ir   = (st == IF && r);
                ex_pc   = (st == IF && r) || (st == ID && (kind == K_J || kind == K_JAL || kind == K_JR)) ||
                          (st == EXE && kind == K_BEQ && z);
                ex_rw   = (st == ID && kind == K_JAL) || st == WB;
                ex_ill  = (st == ID && kind == K_ILL);
                ex_flag = (st == WB && is_addi && ov) ? FLAG_SET : FLAG_DIS;
                ex_npc  = (st == IF) ? NPC_PC4 : (st == EXE) ? NPC_BEQ : (kind == K_JR) ? NPC_REG : NPC_J;
                ex_rd   = (st == ID) ? RD_RET : is_r ? RD_RD : RD_RT;
                ex_m2r  = (st == ID) ? M2R_RET : (kind == K_LW) ? M2R_RAM : M2R_ALU;
                n_chk++;
                if ({bus.state, bus.mem_req, bus.MemWr, bus.IRWr, bus.PCWr, bus.RegWr, bus.illegal, bus.FlagOp} !==
                    {3'(st), ex_mreq, ex_mwr, ex_ir, ex_pc, ex_rw, ex_ill, ex_flag}) begin
                    n_bad++;
                    $display("FAIL rand%0d_op%h_fn%h_cyc%0d got st=%0d req=%b wr=%b ir=%b pc=%b rw=%b ill=%b fl=%0d want st=%0d req=%b wr=%b ir=%b pc=%b rw=%b ill=%b fl=%0d",
                             k, op, fn, i, bus.state, bus.mem_req, bus.MemWr, bus.IRWr, bus.PCWr, bus.RegWr, bus.illegal, bus.FlagOp,
                             st, ex_mreq, ex_mwr, ex_ir, ex_pc, ex_rw, ex_ill, ex_flag);
                end
                if (ex_pc) begin
                    n_chk++;
                    if (bus.NPCSel !== ex_npc) begin
                        n_bad++;
                        $display("FAIL rand%0d_npc got=%0d want=%0d", k, bus.NPCSel, ex_npc);
                    end
                end
                if (ex_rw) begin
                    n_chk++;
                    if ({bus.RegDst, bus.Mem2Reg} !== {ex_rd, ex_m2r}) begin
                        n_bad++;
                        $display("FAIL rand%0d_wb got RegDst=%0d Mem2Reg=%0d want %0d %0d", k, bus.RegDst, bus.Mem2Reg, ex_rd, ex_m2r);
                    end
                end
                if (st >= EXE) begin
                    n_chk++;
                    if ({bus.ALUSrc, bus.EXTOp, bus.ALUOp} !== sel) begin
                        n_bad++;
                        $display("FAIL rand%0d_sel got=%h want=%h", k, {bus.ALUSrc, bus.EXTOp, bus.ALUOp}, sel);
                    end
                end
                tick;
            end
            exp_ret++;
            n_chk++;
            if ({bus.state, bus.retired} !== {3'd0, exp_ret}) begin
                n_bad++;
                $display("FAIL rand%0d_retire got state=%0d retired=%0d want 0 %0d", k, bus.state, bus.retired, exp_ret);
            end
        end
    endtask

    initial begin
        test_reset;
        test_addu;
        test_lw_wait;
        test_sw;
        test_beq;
        test_jal_illegal;
        test_random(300);
        test_reset_mid_mem;
        test_random(60);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
